// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers ROM data into the instruction
// register, and applies halt, taken-branch redirects and decoder stalls.
module fetch_unit #(
    parameter int              IW       = 16,
    parameter int              DW       = 9,
    parameter logic [IW-1:0]   START_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          stall_i,
    input  logic          branch_rel_i,
    input  logic          branch_abs_i,
    input  logic          taken_i,
    input  logic [7:0]    offset_i,
    input  logic [IW-1:0] target_i,
    input  logic          halt_i,
    input  logic [DW-1:0] inst_in_i,
    output logic [IW-1:0] inst_address_o,
    output logic [DW-1:0] inst_out_o,
    output logic          inst_valid_o,
    output logic [IW-1:0] pc_out_o,
    output logic          done_o,
    output logic [15:0]   cycles_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [IW-1:0] pc_out_q, pc_out_d;
    logic [DW-1:0] inst_q, inst_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic [15:0]   cycles_q, cycles_d;

    logic          halt_hit;
    logic          redirect;
    logic [IW-1:0] rel_target;

    // Control inputs describe the instruction in IR, so they only count while it is live.
    assign halt_hit   = valid_q && halt_i;
    assign redirect   = valid_q && taken_i && (branch_rel_i || branch_abs_i);
    assign rel_target = pc_out_q + {{(IW-8){offset_i[7]}}, offset_i};

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        done_d   = done_q;
        cycles_d = cycles_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    pc_d     = START_PC;
                    cycles_d = '0;
                end
            end
            S_RUN: begin
                if (cycles_q != 16'hFFFF) cycles_d = cycles_q + 16'd1;
                if (halt_hit) begin
                    state_d = S_HALTED;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else if (redirect) begin
                    pc_d    = branch_abs_i ? target_i : rel_target;
                    valid_d = 1'b0;
                end else if (!stall_i) begin
                    inst_d   = inst_in_i;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + IW'(1);
                end
            end
            S_HALTED: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    pc_d     = START_PC;
                    cycles_d = '0;
                    done_d   = 1'b0;
                    valid_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            pc_q     <= START_PC;
            pc_out_q <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
        end
    end

    assign inst_address_o = pc_q;
    assign inst_out_o     = inst_q;
    assign inst_valid_o   = valid_q;
    assign pc_out_o       = pc_out_q;
    assign done_o         = done_q;
    assign cycles_o       = cycles_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table feeds an expected-output queue
// checked after each edge, plus hand sequences for halt, restart, reset and saturation.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, brel, babs, taken, halt;
    logic [7:0]  offset;
    logic [15:0] target;
    logic [8:0]  inst_in;
    logic [15:0] inst_address;
    logic [8:0]  inst_out;
    logic        inst_valid;
    logic [15:0] pc_out;
    logic        done;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.IW(16), .DW(9), .START_PC(16'h0000)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .branch_rel_i(brel), .branch_abs_i(babs), .taken_i(taken),
        .offset_i(offset), .target_i(target), .halt_i(halt),
        .inst_in_i(inst_in), .inst_address_o(inst_address),
        .inst_out_o(inst_out), .inst_valid_o(inst_valid),
        .pc_out_o(pc_out), .done_o(done), .cycles_o(cycles)
    );

    // Combinational ROM; mem[0..3] = 001..004
    function automatic logic [8:0] rom_f(input logic [15:0] a);
        logic [15:0] t;
        t = (a + 16'd1) ^ (a >> 9);
        return t[8:0];
    endfunction

    assign inst_in = rom_f(inst_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        v;
        logic        d;
        logic [15:0] pc;
        logic [8:0]  inst;
    } exp_t;

    typedef struct packed {
        logic        stall, rel, abs_, taken, halt;
        logic [7:0]  off;
        logic [15:0] tgt;
        exp_t        e;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[25];

    function automatic vec_t mk(input logic s, input logic r, input logic a, input logic t,
                                input logic h, input logic [7:0] o, input logic [15:0] g,
                                input logic ev, input logic ed, input logic [15:0] epc);
        vec_t x;
        x.stall = s; x.rel = r; x.abs_ = a; x.taken = t; x.halt = h;
        x.off = o; x.tgt = g;
        x.e.v = ev; x.e.d = ed; x.e.pc = epc; x.e.inst = rom_f(epc);
        return x;
    endfunction

    // Scoreboard: each expectation is pushed one half-cycle before its edge.
    always begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("vec pc=%0h {valid,done,pc_out,inst}", e.pc),
                  {5'd0, inst_valid, done, pc_out, inst_out},
                  {5'd0, e.v, e.d, e.pc, e.inst});
        end
    end

    task automatic clear_inputs();
        start = 0; stall = 0; brel = 0; babs = 0; taken = 0; halt = 0;
        offset = 8'h00; target = 16'h0000;
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check({tag, " addr"},   32'(inst_address), 32'h0);
        check({tag, " valid"},  32'(inst_valid),   32'h0);
        check({tag, " done"},   32'(done),         32'h0);
        check({tag, " cycles"}, 32'(cycles),       32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " inst_out"}, 32'(inst_out),     32'h0);
        check({tag, " valid"},    32'(inst_valid),   32'h0);
        check({tag, " pc_out"},   32'(pc_out),       32'h0);
        check({tag, " done"},     32'(done),         32'h0);
        check({tag, " cycles"},   32'(cycles),       32'h0);
        check({tag, " addr"},     32'(inst_address), 32'h0);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 0;

        tbl[0]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0000);
        tbl[1]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0001);
        tbl[2]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0002);
        tbl[3]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0003);
        tbl[4]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0004);
        tbl[5]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0005);
        tbl[6]  = mk(0,1,0,1,0, 8'hFD, 16'h0000, 0,0,16'h0005);
        tbl[7]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0002);
        tbl[8]  = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0003);
        tbl[9]  = mk(0,1,1,1,0, 8'h02, 16'h0020, 0,0,16'h0003);
        tbl[10] = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0020);
        tbl[11] = mk(1,0,1,1,0, 8'h00, 16'h0040, 0,0,16'h0020);
        tbl[12] = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0040);
        tbl[13] = mk(1,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0040);
        tbl[14] = mk(1,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0040);
        tbl[15] = mk(1,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0040);
        tbl[16] = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h0041);
        tbl[17] = mk(0,1,0,0,0, 8'h10, 16'h0000, 1,0,16'h0042);
        tbl[18] = mk(0,0,1,1,0, 8'h00, 16'hFFF0, 0,0,16'h0042);
        tbl[19] = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'hFFF0);
        tbl[20] = mk(0,1,0,1,0, 8'h7F, 16'h0000, 0,0,16'hFFF0);
        tbl[21] = mk(0,0,0,0,0, 8'h00, 16'h0000, 1,0,16'h006F);
        tbl[22] = mk(0,0,1,1,0, 8'h00, 16'h0100, 0,0,16'h006F);
        tbl[23] = mk(0,0,1,1,1, 8'h00, 16'h0200, 1,0,16'h0100);
        tbl[24] = mk(0,0,1,1,1, 8'h00, 16'h0300, 0,1,16'h0100);

        do_start("start1");
        for (int i = 0; i < 25; i++) begin
            stall = tbl[i].stall; brel = tbl[i].rel; babs = tbl[i].abs_;
            taken = tbl[i].taken; halt = tbl[i].halt;
            offset = tbl[i].off; target = tbl[i].tgt;
            sb_q.push_back(tbl[i].e);
            @(negedge clk);
        end
        clear_inputs();
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

        // Halted after the table: PC must not follow the jump issued with Halt.
        repeat (2) @(negedge clk);
        check("halted addr", 32'(inst_address), 32'h0101);
        check("halted done", 32'(done), 32'h1);

        // Asynchronous reset between edges while halted.
        @(posedge clk);
        #3 rst = 1;
        #1 check_reset_values("async rst halted");
        @(negedge clk);
        rst = 0;

        // Halt at PCOut=7 with a taken absolute jump alongside.
        do_start("start2");
        repeat (8) @(negedge clk);
        check("pre-halt pc_out", 32'(pc_out), 32'h7);
        check("pre-halt cycles", 32'(cycles), 32'd8);
        halt = 1; babs = 1; taken = 1; target = 16'h0040;
        @(negedge clk);
        clear_inputs();
        check("halt done",     32'(done),         32'h1);
        check("halt valid",    32'(inst_valid),   32'h0);
        check("halt pc_out",   32'(pc_out),       32'h7);
        check("halt inst_out", 32'(inst_out),     32'(rom_f(16'h7)));
        check("halt addr",     32'(inst_address), 32'h8);
        check("halt cycles",   32'(cycles),       32'd9);
        repeat (3) @(negedge clk);
        check("halted cycles frozen", 32'(cycles),       32'd9);
        check("halted addr frozen",   32'(inst_address), 32'h8);

        // Restart from HALTED, then a Start pulse in RUN must be ignored.
        do_start("restart");
        @(negedge clk);
        check("restart first {valid,pc,inst}", {7'd0, inst_valid, pc_out, inst_out},
              {7'd0, 1'b1, 16'h0000, 9'h001});
        check("restart cycles", 32'(cycles), 32'd1);
        start = 1;
        @(negedge clk);
        start = 0;
        check("start in run pc_out", 32'(pc_out), 32'h1);
        check("start in run cycles", 32'(cycles), 32'd2);
        repeat (3) @(negedge clk);
        check("run pc_out", 32'(pc_out), 32'h4);

        // Asynchronous reset mid-RUN.
        @(posedge clk);
        #3 rst = 1;
        #1 check_reset_values("async rst run");
        @(negedge clk);
        rst = 0;

        // Cycle counter saturation and PC wrap.
        do_start("start3");
        repeat (65534) @(negedge clk);
        check("cycles 65534", 32'(cycles), 32'h0000FFFE);
        @(negedge clk);
        check("cycles sat", 32'(cycles), 32'h0000FFFF);
        @(negedge clk);
        check("wrap pc_out", 32'(pc_out),       32'hFFFF);
        check("wrap addr",   32'(inst_address), 32'h0000);
        repeat (2) @(negedge clk);
        check("cycles held sat", 32'(cycles), 32'h0000FFFF);
        check("wrap pc_out+2",   32'(pc_out), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM. It owns the program counter and drives the ROM address. It registers the returned 9-bit instruction into an instruction register for the decoder, and applies relative/absolute branch redirects, stalls and halt. It also runs a start/done handshake with the testbench and counts executed cycles.

## Interface
- IW, 16, program counter / ROM address width
- DW, 9, instruction width
- START_PC, 0, address of the first instruction after Start
- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- Start  in  1  begin execution; sampled only in IDLE or HALTED
- Stall  in  1  hold current fetch (decoder back-pressure)
- BranchRel  in  1  instruction in IR is a relative branch
- BranchAbs  in  1  instruction in IR is an absolute jump
- Taken  in  1  branch condition true for instruction in IR
- Offset  in  8  signed relative offset, two's complement
- Target  in  IW  absolute jump target
- Halt  in  1  instruction in IR is a halt
- InstIn  in  DW  instruction returned by ROM for InstAddress
- InstAddress  out  IW  ROM address; combinationally equals PC
- InstOut  out  DW  instruction register to decoder
- InstValid  out  1  InstOut holds a live instruction
- PCOut  out  IW  address of the instruction in InstOut
- Done  out  1  program halted
- Cycles  out  16  RUN-state cycle count

## Operation
- States: IDLE (after reset), RUN, HALTED.
- Reset values: PC=START_PC, InstOut=0, InstValid=0, PCOut=0, Done=0, Cycles=0, state=IDLE.
- IDLE:
  - PC held.
  - Start=1 → RUN; PC=START_PC; Cycles=0.
- RUN: per-edge priority is Halt > redirect > Stall > sequential.
- Control inputs (Halt, BranchRel, BranchAbs, Taken) are honored only when InstValid=1. Otherwise they are ignored.
- Halt:
  - State → HALTED; InstValid=0; Done=1.
  - PC, InstOut and PCOut frozen.
- Redirect (Taken & BranchRel):
  - PC ← PCOut + sign_extend(Offset).
  - Arithmetic is modulo 2^IW.
- Redirect (Taken & BranchAbs): PC ← Target.
- Redirect, common to both kinds:
  - InstValid ← 0 (flush the sequentially fetched instruction).
  - InstOut and PCOut hold.
  - If BranchRel and BranchAbs are both set, BranchAbs wins.
- Redirect overrides Stall.
- Stall (no halt/redirect): PC, InstOut, PCOut, InstValid all hold.
- Sequential:
  - InstOut ← InstIn; PCOut ← PC; InstValid ← 1.
  - PC ← PC+1, wrapping from 2^IW−1 to 0.
- Taken=0 with a branch flag set is treated as sequential.
- Cycles increments every RUN-state edge and saturates at 16'hFFFF.
- Cycles holds in IDLE and HALTED.
- HALTED:
  - Done=1.
  - Start=1 → RUN, with PC=START_PC, Cycles=0, Done=0, InstValid=0.
- Start in RUN is ignored.
- Reset asserted mid-RUN forces all reset values immediately (asynchronous); Done drops with it.

## Timing
- InstAddress is combinational from PC; InstIn must settle within the same cycle (combinational ROM).
- Start sampled high at edge k:
  - RUN from k; InstAddress=START_PC in cycle k..k+1.
  - Edge k+1 loads InstOut with mem[START_PC], PCOut=START_PC, InstValid=1.
- Fetch latency is 1 cycle: the instruction at address A appears on InstOut the edge after InstAddress=A.
- Taken branch penalty is 1 bubble cycle (InstValid low for exactly one cycle), then the target instruction.
- Halt seen at edge k: Done=1 and InstValid=0 after edge k; no further PC movement.

## Test plan
- Reset, then Start pulse; ROM mem[0..3]=9'h001..9'h004, no branches → InstOut 001,002,003,004 on consecutive cycles with PCOut 0..3; InstValid high from the first edge after Start.
- With InstValid=1 and PCOut=5, apply BranchRel=1, Taken=1, Offset=8'hFD → one bubble cycle, then PCOut=2 with InstOut=mem[2]. Repeat with Offset=8'h7F at PCOut=16'hFFF0 → PCOut wraps to 16'h006F.
- BranchAbs=1, Taken=1, Target=16'h0040 while Stall=1 → redirect wins: bubble, then PCOut=16'h0040. Separately, Stall held 3 cycles with no branch → InstOut/PCOut frozen, then resume at PC+1.
- Halt at PCOut=7 together with BranchAbs=1 and Taken=1 → HALTED; Done=1, InstValid=0, PC not redirected; Cycles stops. Then Start → Done=0, refetch from START_PC, Cycles restarts at 0.
- Reset asserted asynchronously mid-RUN, between clock edges → all outputs return to reset values immediately. Start pulses in RUN are ignored. Cycles saturates at 16'hFFFF after 65535+ RUN cycles.
